// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the key-schedule blocks.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  localparam int         NR_128     = 10;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Undo xtime: the low bit tells whether 0x1b was folded in on the way up.
  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    logic [7:0] t;
    t = a[0] ? (a ^ 8'h1b) : a;
    return {a[0], t[7:1]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Round-key stream from the inverse key schedule to the inverse cipher.
interface aes_inv_key_sched_if;
  logic         rk_valid;
  logic         rk_ready;
  logic [0:127] rk;
  logic [3:0]   rk_round;
  logic         last;

  modport master(output rk_valid, rk, rk_round, last, input rk_ready);
  modport slave(input rk_valid, rk, rk_round, last, output rk_ready);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, byte 0x00 at the left of the table.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = SBOX[{a, 3'b000} +: 8];
endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key schedule: walks forward to round Nr, then emits
// round keys Nr..0 by running the recurrence backwards on one working key.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = NR_128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [0:32*Nk-1]     Key,
  output logic                 busy,
  aes_inv_key_sched_if.master  rk_if
);
  localparam logic [3:0] R_LAST_FWD = 4'(Nr - 1);

  state_t       state_reg, state_next;
  logic [127:0] w_reg, w_next;
  logic [3:0]   r_reg, r_next;
  logic [7:0]   rcon_reg, rcon_next;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_in, sub_out, t;
  logic [127:0] w_fwd, w_rev;
  logic         rev;

  assign {w0, w1, w2, w3} = w_reg;
  assign rev = (state_reg == REV);

  // Backwards, the S-box needs the previous w3, which is w3 ^ w2.
  assign sub_in = rot_word(rev ? (w3 ^ w2) : w3);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .a(sub_in[8*gi +: 8]),
        .s(sub_out[8*gi +: 8])
      );
    end
  endgenerate

  // Forward words are expressed as prefix XORs so only one XOR follows t.
  assign t     = sub_out ^ {rcon_reg, 24'h0};
  assign w_fwd = {w0 ^ t, w0 ^ w1 ^ t, w0 ^ w1 ^ w2 ^ t, w0 ^ w1 ^ w2 ^ w3 ^ t};
  assign w_rev = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  always_comb begin
    state_next = state_reg;
    w_next     = w_reg;
    r_next     = r_reg;
    rcon_next  = rcon_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          w_next     = Key;
          r_next     = 4'd0;
          rcon_next  = RCON_FIRST;
          state_next = FWD;
        end
      end
      FWD: begin
        w_next = w_fwd;
        r_next = r_reg + 4'd1;
        if (r_reg == R_LAST_FWD) begin
          rcon_next  = RCON_LAST;
          state_next = REV;
        end else begin
          rcon_next = xtime(rcon_reg);
        end
      end
      REV: begin
        if (rk_if.rk_ready) begin
          if (r_reg == 4'd0) begin
            state_next = IDLE;
          end else begin
            w_next    = w_rev;
            r_next    = r_reg - 4'd1;
            rcon_next = inv_xtime(rcon_reg);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      w_reg     <= '0;
      r_reg     <= 4'd0;
      rcon_reg  <= RCON_FIRST;
    end else begin
      state_reg <= state_next;
      w_reg     <= w_next;
      r_reg     <= r_next;
      rcon_reg  <= rcon_next;
    end
  end

  assign busy           = (state_reg != IDLE);
  assign rk_if.rk_valid = rev;
  assign rk_if.rk       = rev ? w_reg : '0;
  assign rk_if.rk_round = rev ? r_reg : 4'd0;
  assign rk_if.last     = rev && (r_reg == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench: FIPS-197 style forward expansion model, reverse-order expectations.
module tb_aes_inv_key_sched;

  typedef struct {
    logic [127:0] rk;
    logic [3:0]   round;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [0:127] Key;
  logic         busy;
  bit           bp_en = 1'b0;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb_q[$];
  logic [127:0] seen [11];
  logic [7:0]   sbox_m [256];

  logic [127:0] fips_key, fips_r10, fips_r9, fips_r1, zero_r10, seq_key, seq_r10;

  aes_inv_key_sched_if rk_if ();

  aes_inv_key_sched #(.Nk(4), .Nr(10)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .Key(Key),
    .busy(busy),
    .rk_if(rk_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key, output logic [127:0] rks [11]);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Compares every presented key against the queue head; pops only on handshake.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rk_if.rk_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", {124'h0, rk_if.rk_round}, 128'hffff);
        end else begin
          e = sb_q[0];
          chk("rk", rk_if.rk, e.rk);
          chk("rk_round", rk_if.rk_round, e.round);
          chk("last", rk_if.last, e.round == 4'd0);
          if (rk_if.rk_ready) begin
            void'(sb_q.pop_front());
            seen[rk_if.rk_round] = rk_if.rk;
            $display("key round=%0d rk=%h last=%0b", rk_if.rk_round, rk_if.rk, rk_if.last);
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    chk("rst_busy", busy, 0);
    chk("rst_valid", rk_if.rk_valid, 0);
    chk("rst_rk", rk_if.rk, 0);
    chk("rst_round", rk_if.rk_round, 0);
    chk("rst_last", rk_if.last, 0);
  endtask

  task automatic do_run(input logic [127:0] key, input bit bp, input bit inject,
                        input int rst_fwd, input int rst_round);
    logic [127:0] rks [11];
    int cycles;
    int lat;
    expand(key, rks);
    for (int r = 10; r >= 0; r--) sb_q.push_back('{rk: rks[r], round: 4'(r)});
    bp_en = bp;
    Key   = key;
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    lat    = 0;
    while (busy && cycles < 400) begin
      if (lat == 0 && rk_if.rk_valid) lat = cycles;
      if ((rst_fwd == cycles) ||
          (rst_round >= 0 && rk_if.rk_valid && rk_if.rk_round == 4'(rst_round))) begin
        apply_reset();
        return;
      end
      if (inject && (cycles == 4 || cycles == 14)) begin
        start = 1'b1;
        Key   = ~key;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    chk("first_valid_latency", lat, 11);
    chk("queue_drained", sb_q.size(), 0);
    if (!bp) chk("run_cycles", cycles, 22);
    chk("busy_after", busy, 0);
    sb_q.delete();
  endtask

  initial begin
    rk_if.rk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rk_if.rk_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    fips_r9  = 128'hac7766f319fadc2128d12941575c006e;
    fips_r1  = 128'ha0fafe1788542cb123a339392a6c7605;
    zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    seq_key  = 128'h000102030405060708090a0b0c0d0e0f;
    seq_r10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst   = 1'b1;
    start = 1'b0;
    Key   = '0;
    build_sbox();
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", rk_if.rk_valid, 0);
    chk("reset_rk", rk_if.rk, 0);
    chk("reset_last", rk_if.last, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_run(fips_key, 1'b0, 1'b0, -1, -1);
    chk("fips_r10", seen[10], fips_r10);
    chk("fips_r9", seen[9], fips_r9);
    chk("fips_r1", seen[1], fips_r1);
    chk("fips_r0", seen[0], fips_key);

    seen[10] = '0;
    do_run(fips_key, 1'b1, 1'b0, -1, -1);
    chk("fips_bp_r10", seen[10], fips_r10);

    seen[0] = '1;
    do_run(128'h0, 1'b0, 1'b0, -1, -1);
    chk("zero_r10", seen[10], zero_r10);
    chk("zero_r0", seen[0], 0);

    seen[10] = '0;
    do_run(fips_key, 1'b0, 1'b1, -1, -1);
    chk("inject_r10", seen[10], fips_r10);

    do_run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 5, -1);
    do_run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, -1, 6);
    seen[9] = '0;
    do_run(fips_key, 1'b0, 1'b0, -1, -1);
    chk("after_rst_r9", seen[9], fips_r9);

    for (int n = 0; n < 4; n++)
      do_run({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, -1, -1);

    seen[10] = '0;
    do_run(seq_key, 1'b0, 1'b0, -1, -1);
    chk("b2b_r10", seen[10], seq_r10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Sequential AES-128 round-key generator for the decryption datapath.
- Takes the cipher key, runs the forward schedule iteratively (one round key per cycle) to reach round key Nr, then emits round keys in reverse order, Nr down to 0, over a valid/ready stream.
- Regenerates each earlier key with the inverse recurrence instead of storing all 11 keys, trading the 1408-bit register for one 128-bit working key.
- Feeds the inverse-cipher round loop, which consumes the last round key first.

Parameters:
- Nk, 4, key length in 32-bit words; only 4 is legal.
- Nr, 10, number of rounds; only 10 is legal.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- Key  in  [0:32*Nk-1]  cipher key.
  - Word 0 is bits [0:31].
  - Byte 0 is the MSB of word 0.
- busy  out  1  high in every state except IDLE.
- rk_valid  out  1  rk, rk_round and last are valid.
- rk_ready  in  1  consumer accepts the current key.
- rk  out  [0:127]  current round key, same word/byte order as Key.
- rk_round  out  4  round index of rk (10..0).
- last  out  1  high together with rk_valid when rk_round==0.

Behaviour:
- Reset values: state=IDLE, busy=0, rk_valid=0, rk=0, rk_round=0, last=0, rcon=8'h01.
- IDLE, start=1:
  - Latch Key into the working key W.
  - Set round counter r=0 and rcon=8'h01.
  - Go to FWD.
- IDLE, start=0: stay in IDLE.
- FWD, each cycle, computes W <= next(W, rcon), rcon <= xtime(rcon), r <= r+1. next() is:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- RotWord is a left byte-rotate.
- xtime(a) = {a[6:0],0}, then XOR 8'h1b if a[7]=1.
- When r reaches Nr, go to REV:
  - rcon holds 8'h36 (Rcon of round 10).
  - rk_valid asserts the cycle after the 10th FWD cycle, i.e. 11 cycles after the start edge.
- REV: rk=W, rk_round=r, rk_valid=1.
- On handshake (rk_valid & rk_ready) with r>0, W <= prev(W, rcon), r <= r-1, rcon <= inv_xtime(rcon). prev() is:
  - w3' = w3 ^ w2
  - w2' = w2 ^ w1
  - w1' = w1 ^ w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon, 24'h0}
- inv_xtime(a) = (a[0] ? (a ^ 8'h1b) : a) >> 1, with bit 7 set when a[0]=1.
- The next key is presented the following cycle, so the sustained rate is one key per cycle with rk_ready held high.
- rk_ready=0: rk, rk_round and last hold stable; no state change.
- Handshake with r==0 (last=1):
  - Go to IDLE.
  - rk_valid and busy drop the next cycle.
  - A new start is accepted from that IDLE cycle onward.
- start while busy: ignored; Key is not resampled.
- Key changing after the start cycle: no effect.
- rst mid-operation: return to IDLE with reset values on the next edge; any partial sequence is discarded.
- Datapath size: exactly one SubWord instance (4 S-boxes), shared by FWD and REV through a mux on its input word.
- Critical path: one SubWord plus three XOR levels.

Decomposition:
- Package aes_pkg holds:
  - state enum {IDLE, FWD, REV};
  - RCON_FIRST = 8'h01 and RCON_LAST = 8'h36;
  - xtime and inv_xtime functions;
  - RotWord function;
  - constant NR_128 = 10.
- Sub-module aes_sbox: combinational 8-bit S-box, instantiated 4 times as SubWord.
- The encryption-side key expansion reuses the same aes_sbox and aes_pkg.

Test Plan:
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, start pulse, rk_ready=1:
  - first rk_valid at start+11;
  - round 10 rk = d014f9a8 c9ee2589 e13f0cc8 b6630ca6;
  - then round 9 = ac7766f3 19fadc21 28d12941 575c006e;
  - round 1 = a0fafe17 88542cb1 23a33939 2a6c7605;
  - round 0 = the key with last=1;
  - 11 keys on consecutive cycles, then busy=0.
- Same key with random rk_ready backpressure: identical 11-key sequence; rk, rk_round and last stable while rk_ready=0.
- Key 00..00:
  - round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e;
  - round 0 = all zero.
- start asserted during FWD and during REV with a different Key: ignored; the sequence is unchanged.
- rst asserted at the 5th FWD cycle and again at round 6 in REV: the next cycle is IDLE with all outputs zero; a following start produces the full correct sequence.
- Back-to-back: start in the first IDLE cycle after last handshake with key 000102..0f → round 10 = 13111d7f e3944a17 f307a78b 4d2b30c5.
